// File: rtl/skolem_cert_checker_if.sv
// Handshake between the certificate checker and the Skolem function under test:
// the checker presents an assignment x and the function answers with candidate outputs y.
interface skolem_cert_checker_if #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 2
) ();
  logic [N_IN-1:0]  x_out;
  logic             x_valid;
  logic [N_OUT-1:0] y_in;
  logic             y_valid;

  modport master (output x_out, x_valid, input  y_in, y_valid);
  modport slave  (input  x_out, x_valid, output y_in, y_valid);
endinterface

// File: rtl/skolem_cert_checker.sv
// Exhaustive Skolem certificate checker: sweeps every x, captures y and judges each
// (x,y) pair against the SPEC truth table, tracking errors, unrealizable x and the first counterexample.
module skolem_cert_checker #(
  parameter int                            N_IN    = 5,
  parameter int                            N_OUT   = 2,
  parameter logic [2**(N_IN+N_OUT)-1:0]    SPEC    = {2**(N_IN+N_OUT){1'b1}},
  parameter int                            TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  skolem_cert_checker_if.master    fut,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [N_IN:0]            err_count,
  output logic [N_IN:0]            unreal_cnt,
  output logic                     cex_valid,
  output logic [N_IN-1:0]          cex_x,
  output logic [N_OUT-1:0]         cex_y
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, EVAL, FIN} state_t;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  x_q;
  logic [N_OUT-1:0] y_q;
  logic [WW-1:0]    wait_cnt;
  logic             ok, real_x, err_inc, unreal_inc, last_x, wait_exp;

  // Judge the captured pair; x is realizable if any y' satisfies the table.
  always_comb begin
    ok     = SPEC[{y_q, x_q}];
    real_x = 1'b0;
    for (int unsigned j = 0; j < (32'd1 << N_OUT); j++) begin
      real_x = real_x | SPEC[{N_OUT'(j), x_q}];
    end
    err_inc    = (state == EVAL) && real_x && !ok;
    unreal_inc = (state == EVAL) && !real_x;
    last_x     = &x_q;
    wait_exp   = (wait_cnt == WW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (fut.y_valid) state_nxt = EVAL;
               else if (wait_exp) state_nxt = FIN;
      EVAL:    state_nxt = last_x ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fut.x_out   = x_q;
    fut.x_valid = (state == DRIVE);
    busy        = (state != IDLE);
    done        = (state == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      wait_cnt   <= '0;
      err_count  <= '0;
      unreal_cnt <= '0;
      timeout    <= 1'b0;
      pass       <= 1'b0;
      cex_valid  <= 1'b0;
      cex_x      <= '0;
      cex_y      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_q        <= '0;
          wait_cnt   <= '0;
          err_count  <= '0;
          unreal_cnt <= '0;
          timeout    <= 1'b0;
          pass       <= 1'b0;
          cex_valid  <= 1'b0;
          cex_x      <= '0;
          cex_y      <= '0;
        end
        DRIVE: begin
          if (fut.y_valid) begin
            y_q <= fut.y_in;
          end else if (wait_exp) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EVAL: begin
          if (unreal_inc && (unreal_cnt != '1)) unreal_cnt <= unreal_cnt + 1'b1;
          if (err_inc && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
            if (!cex_valid) begin
              cex_valid <= 1'b1;
              cex_x     <= x_q;
              cex_y     <= y_q;
            end
          end
          // Verdict is registered on FIN entry so it is already valid while done pulses.
          if (last_x) begin
            pass <= (err_count == '0) && !err_inc;
          end else begin
            x_q      <= x_q + 1'b1;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
